// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine with optional write-verify readback.
// Drives one port of an async-read / sync-write RAM; every output is registered.
module mem_copy_engine #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] src_addr,
    input  logic [AWIDTH-1:0] dst_addr,
    input  logic [AWIDTH-1:0] len,
    input  logic              verify,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [AWIDTH-1:0] src_q;
    logic [AWIDTH-1:0] dst_q;
    logic [AWIDTH-1:0] len_q;
    logic [AWIDTH-1:0] idx_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] err_addr_q;
    logic [DWIDTH-1:0] buf_q;
    logic              verify_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [AWIDTH-1:0] idx_d;
    logic              last_word;

    // Address sums are AWIDTH wide, so src+i / dst+i wrap modulo 2^AWIDTH.
    assign idx_d     = idx_q + AWIDTH'(1);
    assign last_word = (idx_d == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            err_addr_q <= '0;
            buf_q      <= '0;
            verify_q   <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len;
                        verify_q   <= verify;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        err_addr_q <= '0;
                        busy_q     <= 1'b1;
                        if (len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            addr_q  <= src_addr;
                        end
                    end
                end

                S_READ: begin
                    buf_q   <= mem_rdata;
                    addr_q  <= dst_q + idx_q;
                    we_q    <= 1'b1;
                    state_q <= S_WRITE;
                end

                S_WRITE: begin
                    we_q <= 1'b0;
                    if (verify_q) begin
                        state_q <= S_CHECK;
                    end else begin
                        idx_q <= idx_d;
                        if (last_word) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            addr_q  <= src_q + idx_d;
                        end
                    end
                end

                S_CHECK: begin
                    // A mismatch abandons the remaining words immediately.
                    if (mem_rdata != buf_q) begin
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                    end else begin
                        idx_q <= idx_d;
                        if (last_word) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            addr_q  <= src_q + idx_d;
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = buf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a behavioural async-read / sync-write RAM
// plus hand-computed expectations for latency, RAM contents and error reporting.
module tb_mem_copy_engine;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 12;

    logic              clk;
    logic              reset;
    logic              start;
    logic [AWIDTH-1:0] src_addr;
    logic [AWIDTH-1:0] dst_addr;
    logic [AWIDTH-1:0] len;
    logic              verify;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [AWIDTH-1:0] err_addr;

    logic [DWIDTH-1:0] ram [0:(1<<AWIDTH)-1];
    int                wr_count;
    logic              inj;

    int n_vec;
    int n_err;

    mem_copy_engine #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .verify    (verify),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; inj corrupts only the readback of dst word 0x201.
    assign mem_rdata = (inj && !mem_we && mem_addr == 12'h201) ? '0 : ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [AWIDTH-1:0] s, input logic [AWIDTH-1:0] d,
                        input logic [AWIDTH-1:0] n, input logic v);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        verify   = v;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle (1-based, after the sampling edge) where done is seen, -1 on timeout.
    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [AWIDTH-1:0] s, input logic [AWIDTH-1:0] d,
                       input logic [AWIDTH-1:0] n, input logic v, input int exp_cyc);
        int   cyc;
        logic bok;
        kick(s, d, n, v);
        wait_done(cyc, bok);
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_busy_held"}, bok, 1'b1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int w0;
        n_vec    = 0;
        n_err    = 0;
        wr_count = 0;
        inj      = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        verify   = 1'b0;
        for (int a = 0; a < (1 << AWIDTH); a++) ram[a] <= '0;

        ram[12'h100] <= 32'hFFFF_FFFF;
        ram[12'h101] <= 32'hFFFF_CAFE;
        ram[12'h102] <= 32'h1234_5678;
        ram[12'hFFF] <= 32'h1111_2222;
        ram[12'h000] <= 32'h3333_4444;
        ram[12'h300] <= 32'hA0A0_0001;
        ram[12'h301] <= 32'hA0A0_0002;
        ram[12'h302] <= 32'hA0A0_0003;
        ram[12'h303] <= 32'hA0A0_0004;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, 12'h000);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 12'h000);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Plain copy, two words
        w0 = wr_count;
        run("cp2", 12'h100, 12'h200, 12'd2, 1'b0, 5);
        chk("cp2_ram200", ram[12'h200], 32'hFFFF_FFFF);
        chk("cp2_ram201", ram[12'h201], 32'hFFFF_CAFE);
        chk("cp2_writes", wr_count - w0, 2);
        chk("cp2_err", err, 1'b0);

        // Same copy with verify
        ram[12'h200] <= '0;
        ram[12'h201] <= '0;
        w0 = wr_count;
        run("vfy2", 12'h100, 12'h200, 12'd2, 1'b1, 7);
        chk("vfy2_ram200", ram[12'h200], 32'hFFFF_FFFF);
        chk("vfy2_ram201", ram[12'h201], 32'hFFFF_CAFE);
        chk("vfy2_writes", wr_count - w0, 2);
        chk("vfy2_err", err, 1'b0);

        // Zero length
        w0 = wr_count;
        run("len0", 12'h100, 12'h500, 12'd0, 1'b1, 1);
        chk("len0_writes", wr_count - w0, 0);
        chk("len0_ram500", ram[12'h500], 32'h0);

        // Verify mismatch on dst 0x201 abandons word 2
        ram[12'h200] <= '0;
        ram[12'h201] <= '0;
        ram[12'h202] <= '0;
        inj = 1'b1;
        w0  = wr_count;
        run("mis", 12'h100, 12'h200, 12'd3, 1'b1, 7);
        inj = 1'b0;
        chk("mis_err", err, 1'b1);
        chk("mis_err_addr", err_addr, 12'h201);
        chk("mis_writes", wr_count - w0, 2);
        chk("mis_ram201", ram[12'h201], 32'hFFFF_CAFE);
        chk("mis_ram202", ram[12'h202], 32'h0);
        repeat (3) @(negedge clk);
        chk("mis_err_sticky", err, 1'b1);
        chk("mis_err_addr_sticky", err_addr, 12'h201);

        // Address wrap; new start also clears the sticky error
        w0 = wr_count;
        run("wrap", 12'hFFF, 12'h010, 12'd2, 1'b0, 5);
        chk("wrap_ram010", ram[12'h010], 32'h1111_2222);
        chk("wrap_ram011", ram[12'h011], 32'h3333_4444);
        chk("wrap_writes", wr_count - w0, 2);
        chk("wrap_err_clr", err, 1'b0);
        chk("wrap_err_addr_clr", err_addr, 12'h000);

        // Reset in cycle 3 of a four-word copy
        w0 = wr_count;
        kick(12'h300, 12'h400, 12'd4, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_we", mem_we, 1'b0);
        chk("midrst_addr", mem_addr, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_writes", wr_count - w0, 1);
        chk("midrst_ram400", ram[12'h400], 32'hA0A0_0001);
        chk("midrst_ram401", ram[12'h401], 32'h0);
        chk("midrst_ram403", ram[12'h403], 32'h0);

        run("after_rst", 12'h302, 12'h500, 12'd1, 1'b1, 4);
        chk("after_rst_ram500", ram[12'h500], 32'hA0A0_0003);
        chk("after_rst_err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DWIDTH, default 32, memory data width.
REQ-002 Parameter AWIDTH, default 12, memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  copy request; sampled only in IDLE.
REQ-006 src_addr  input  AWIDTH  first source word address.
REQ-007 dst_addr  input  AWIDTH  first destination word address.
REQ-008 len  input  AWIDTH  word count; 0 means no transfer.
REQ-009 verify  input  1  when 1, each written word is read back and compared.
REQ-010 mem_addr  output  AWIDTH  address to the data port of an async-read, sync-write dual-port RAM.
REQ-011 mem_we  output  1  RAM write enable; the write occurs at the rising clk edge.
REQ-012 mem_wdata  output  DWIDTH  RAM write data.
REQ-013 mem_rdata  input  DWIDTH  combinational RAM read data for mem_addr.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  sticky verify-mismatch flag.
REQ-017 err_addr  output  AWIDTH  destination address of the first mismatch.

Function
REQ-018 FSM states: IDLE, READ, WRITE, CHECK, DONE.
REQ-019 In IDLE with start=1, capture src_addr, dst_addr, len and verify; clear err, err_addr and the word index i; go to READ, or to DONE if len=0.
REQ-020 In IDLE, start=0 holds the FSM in IDLE; start in any other state is ignored.
REQ-021 READ: mem_addr=src+i, mem_we=0; latch mem_rdata into the word buffer; go to WRITE.
REQ-022 WRITE: mem_addr=dst+i, mem_we=1, mem_wdata=buffer; go to CHECK if verify=1, otherwise advance.
REQ-023 CHECK: mem_addr=dst+i, mem_we=0; compare mem_rdata with buffer.
REQ-024 On a CHECK mismatch, set err=1 and err_addr=dst+i, then go to DONE, abandoning the remaining words.
REQ-025 On a CHECK match, advance.
REQ-026 Advance: i=i+1; if i equals the captured len, go to DONE, else go to READ.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Address arithmetic is modulo 2^AWIDTH; src+i and dst+i wrap silently past the top address.
REQ-029 Words copy in ascending order with one read-then-write per word; overlapping regions follow that sequential semantics, with no overlap detection.
REQ-030 Latency (cycles counted after the start-sampling edge):
- verify=0: done is high in cycle 2N+1.
- verify=1 with no mismatch: done is high in cycle 3N+1.
- len=0: done is high in cycle 1.
REQ-031 mem_we is high only in WRITE; in every other state mem_wdata holds the buffer and mem_addr holds its last value.
REQ-032 err and err_addr hold their values until the next accepted start.

Reset
REQ-033 While reset=1, regardless of clk: state=IDLE, mem_we=0, busy=0, done=0, err=0, err_addr=0, mem_addr=0, mem_wdata=0, i=0, buffer=0.
REQ-034 Reset asserted mid-transfer drops mem_we immediately, so no RAM write occurs at any edge while reset=1; words already written stay written.
REQ-035 The first start is accepted at the first rising edge after reset deasserts.

Verification
REQ-036 RAM[0x100]=0xFFFFFFFF, RAM[0x101]=0xFFFFCAFE; start with src=0x100, dst=0x200, len=2, verify=0 -> RAM[0x200]=0xFFFFFFFF, RAM[0x201]=0xFFFFCAFE, done in cycle 5, busy high in cycles 1-5.
REQ-037 Same transfer with verify=1 -> identical RAM contents, done in cycle 7, err=0.
REQ-038 len=0 -> done in cycle 1, mem_we never asserted, RAM unchanged.
REQ-039 src=0xFFF, dst=0x010, len=2 -> RAM[0x010]=RAM[0xFFF], RAM[0x011]=RAM[0x000] (address wrap).
REQ-040 verify=1 with a bench model that forces mem_rdata=0 in CHECK for the word at dst 0x201 -> err=1, err_addr=0x201, done in cycle 7, no further writes.
REQ-041 Reset pulse in cycle 3 of a len=4 copy -> busy=0 at once, mem_we=0, only RAM[dst] written; a new start afterwards completes normally.
